appx_mult_acc: RTL

Downstream accumulation stage for the 32-bit approximate multipliers. It consumes a stream of unsigned 64-bit product magnitudes plus a sign bit and sums them, with sign, into a wide internal accumulator. At a `last` marker it presents a saturated signed 64-bit dot-product result over a valid/ready handshake. It sits directly after the combinational multiplier output and feeds the result writeback/compare logic of the functional-unit test harness.

---
 rtl/appx_mult_acc_if.sv | 26 ++
 rtl/appx_mult_acc.sv | 126 ++++++++++++
 2 files changed

// File: rtl/appx_mult_acc_if.sv
// Term-in / result-out handshake bundle for the signed accumulation stage.
// slave is the accumulator's view; master is the producer/consumer harness view.
interface appx_mult_acc_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_prod;
  logic             in_neg;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_sum;
  logic             out_sat;
  logic [CNT_W-1:0] out_count;

  modport slave (
    input  in_valid, in_prod, in_neg, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_sat, out_count
  );

  modport master (
    output in_valid, in_prod, in_neg, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_sat, out_count
  );
endinterface

// File: rtl/appx_mult_acc.sv
// Signed saturating sum of 64-bit product terms; result is registered on the edge that takes the last term.
// The input stalls (in_ready = 0) while a result waits in HOLD for out_ready.
module appx_mult_acc #(
  parameter int ACC_W = 80,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  appx_mult_acc_if.slave io
);
  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [63:0]      out_sum_q, out_sum_d;
  logic             out_sat_q, out_sat_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  logic             in_ready;
  logic             accept;
  logic [64:0]      term;
  logic [ACC_W:0]   sum_ext;
  logic             acc_clamp;
  logic [ACC_W-1:0] acc_new;
  logic             fits64;
  logic [63:0]      sum64;
  logic [CNT_W-1:0] cnt_new;

  assign in_ready = (state_q == ST_ACCUM) & rst_n;
  assign accept   = io.in_valid & in_ready;

  // One extra guard bit on the sum exposes signed overflow of the ACC_W accumulator.
  always_comb begin
    term      = io.in_neg ? (65'd0 - {1'b0, io.in_prod}) : {1'b0, io.in_prod};
    sum_ext   = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-64){term[64]}}, term};
    acc_clamp = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
    if (!acc_clamp) begin
      acc_new = sum_ext[ACC_W-1:0];
    end else if (sum_ext[ACC_W]) begin
      acc_new = {1'b1, {(ACC_W-1){1'b0}}};
    end else begin
      acc_new = {1'b0, {(ACC_W-1){1'b1}}};
    end

    // Value fits in 64 bits signed when every bit above bit 62 matches.
    fits64 = (&acc_new[ACC_W-1:63]) | ~(|acc_new[ACC_W-1:63]);
    if (fits64) begin
      sum64 = acc_new[63:0];
    end else if (acc_new[ACC_W-1]) begin
      sum64 = 64'h8000_0000_0000_0000;
    end else begin
      sum64 = 64'h7FFF_FFFF_FFFF_FFFF;
    end

    cnt_new = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_sat_d   = out_sat_q;
    out_count_d = out_count_q;
    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          acc_d = acc_new;
          cnt_d = cnt_new;
          ovf_d = ovf_q | acc_clamp;
          if (io.in_last) begin
            out_sum_d   = sum64;
            out_sat_d   = ovf_q | acc_clamp | ~fits64;
            out_count_d = cnt_new;
            out_valid_d = 1'b1;
            state_d     = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (out_valid_q & io.out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          state_d     = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_sat_q   <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_sat_q   <= out_sat_d;
      out_count_q <= out_count_d;
    end
  end

  assign io.in_ready  = in_ready;
  assign io.out_valid = out_valid_q;
  assign io.out_sum   = out_sum_q;
  assign io.out_sat   = out_sat_q;
  assign io.out_count = out_count_q;
endmodule
